// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a
//   valid/ready handshake, then shifts it out one bit per accepted beat on a
//   serial valid/ready stream, flagging the final beat with Ser_last.
//
// Parameters
//   WIDTH      data bits per word (2..16)
//   LSB_FIRST  1: bit 0 goes out first; 0: bit WIDTH-1 goes out first
//
// Ports
//   Clk        rising-edge clock
//   Rst_l      asynchronous active-low reset
//   D          parallel data word
//   In_valid   D is valid this cycle
//   In_ready   block can accept a word (registered)
//   Ser_ready  downstream accepts the current serial beat
//   Ser_out    current serial bit (registered, 0 while Ser_valid=0)
//   Ser_valid  Ser_out is valid (registered)
//   Ser_last   current beat is the final beat of the word (registered)
//   Busy       a word is in flight (registered)
//
// Build option
//   PISO_SERIALIZER_PARITY_EN  when defined, an extra even-parity beat
//   (XOR of the captured word) follows the data beats and carries Ser_last.

module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic             Clk,
    input  logic             Rst_l,
    input  logic [WIDTH-1:0] D,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic             Ser_ready,
    output logic             Ser_out,
    output logic             Ser_valid,
    output logic             Ser_last,
    output logic             Busy
);

    localparam int unsigned CW = $clog2(WIDTH);

`ifdef PISO_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
    // The parity beat carries Ser_last, so no data beat does.
    localparam logic LAST_ON_DATA = 1'b0;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
    localparam logic LAST_ON_DATA = 1'b1;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             in_ready_nxt;
    logic             ser_out_nxt;
    logic             ser_valid_nxt;
    logic             ser_last_nxt;
    logic             busy_nxt;

`ifdef PISO_SERIALIZER_PARITY_EN
    logic             parity_q, parity_nxt;
`endif

    // Helper terms for the shift path
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_inc;
    logic             beat;
    logic             final_data;
    logic             first_bit;
    logic             next_bit;

    always_comb begin
        // The register moves toward the bit that goes out next, so the
        // presented bit always sits at the same end of the shifted value.
        if (LSB_FIRST != 0) begin
            shifted   = sreg >> 1;
            first_bit = D[0];
            next_bit  = shifted[0];
        end else begin
            shifted   = sreg << 1;
            first_bit = D[WIDTH-1];
            next_bit  = shifted[WIDTH-1];
        end
        cnt_inc    = cnt + CW'(1);
        beat       = Ser_valid && Ser_ready;
        final_data = (cnt == CW'(WIDTH - 1));
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        sreg_nxt      = sreg;
        cnt_nxt       = cnt;
        in_ready_nxt  = In_ready;
        ser_out_nxt   = Ser_out;
        ser_valid_nxt = Ser_valid;
        ser_last_nxt  = Ser_last;
        busy_nxt      = Busy;
`ifdef PISO_SERIALIZER_PARITY_EN
        parity_nxt    = parity_q;
`endif

        unique case (state)
            IDLE: begin
                in_ready_nxt  = 1'b1;
                ser_out_nxt   = 1'b0;
                ser_valid_nxt = 1'b0;
                ser_last_nxt  = 1'b0;
                busy_nxt      = 1'b0;
                // In_ready is the registered flag, so the first edge after
                // reset release only raises it and never accepts a word.
                if (In_valid && In_ready) begin
                    state_nxt     = SHIFT;
                    sreg_nxt      = D;
                    cnt_nxt       = '0;
                    in_ready_nxt  = 1'b0;
                    ser_out_nxt   = first_bit;
                    ser_valid_nxt = 1'b1;
                    ser_last_nxt  = 1'b0;
                    busy_nxt      = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
                    parity_nxt    = ^D;
`endif
                end
            end

            SHIFT: begin
                if (beat) begin
                    if (final_data) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                        state_nxt     = PAR;
                        ser_out_nxt   = parity_q;
                        ser_last_nxt  = 1'b1;
`else
                        state_nxt     = IDLE;
                        sreg_nxt      = '0;
                        cnt_nxt       = '0;
                        in_ready_nxt  = 1'b1;
                        ser_out_nxt   = 1'b0;
                        ser_valid_nxt = 1'b0;
                        ser_last_nxt  = 1'b0;
                        busy_nxt      = 1'b0;
`endif
                    end else begin
                        sreg_nxt     = shifted;
                        cnt_nxt      = cnt_inc;
                        ser_out_nxt  = next_bit;
                        ser_last_nxt = LAST_ON_DATA && (cnt_inc == CW'(WIDTH - 1));
                    end
                end
            end

`ifdef PISO_SERIALIZER_PARITY_EN
            PAR: begin
                if (beat) begin
                    state_nxt     = IDLE;
                    sreg_nxt      = '0;
                    cnt_nxt       = '0;
                    in_ready_nxt  = 1'b1;
                    ser_out_nxt   = 1'b0;
                    ser_valid_nxt = 1'b0;
                    ser_last_nxt  = 1'b0;
                    busy_nxt      = 1'b0;
                end
            end
`endif

            default: begin
                state_nxt     = IDLE;
                in_ready_nxt  = 1'b0;
                ser_out_nxt   = 1'b0;
                ser_valid_nxt = 1'b0;
                ser_last_nxt  = 1'b0;
                busy_nxt      = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge Clk or negedge Rst_l) begin
        if (!Rst_l) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            In_ready  <= 1'b0;
            Ser_out   <= 1'b0;
            Ser_valid <= 1'b0;
            Ser_last  <= 1'b0;
            Busy      <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            cnt       <= cnt_nxt;
            In_ready  <= in_ready_nxt;
            Ser_out   <= ser_out_nxt;
            Ser_valid <= ser_valid_nxt;
            Ser_last  <= ser_last_nxt;
            Busy      <= busy_nxt;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_q  <= parity_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: an LSB-first and an MSB-first instance share
// every input; expected beats are queued on word acceptance and a negedge
// monitor compares them whenever Ser_valid is high.

module tb_piso_serializer;

    localparam int unsigned W = 4;

    logic         Clk = 1'b0;
    logic         Rst_l;
    logic [W-1:0] D;
    logic         In_valid;
    logic         Ser_ready;

    logic in_ready_a, ser_out_a, ser_valid_a, ser_last_a, busy_a;
    logic in_ready_b, ser_out_b, ser_valid_b, ser_last_b, busy_b;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut_lsb (
        .Clk(Clk), .Rst_l(Rst_l), .D(D), .In_valid(In_valid), .In_ready(in_ready_a),
        .Ser_ready(Ser_ready), .Ser_out(ser_out_a), .Ser_valid(ser_valid_a),
        .Ser_last(ser_last_a), .Busy(busy_a)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut_msb (
        .Clk(Clk), .Rst_l(Rst_l), .D(D), .In_valid(In_valid), .In_ready(in_ready_b),
        .Ser_ready(Ser_ready), .Ser_out(ser_out_b), .Ser_valid(ser_valid_b),
        .Ser_last(ser_last_b), .Busy(busy_b)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic bit_lsb;
        logic bit_msb;
        logic last;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    logic  rdy_rand = 1'b0;

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int unsigned BEATS = W + 1;
`else
    localparam int unsigned BEATS = W;
`endif

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: word d becomes W data beats in the chosen bit order, plus an
    // even-parity beat when the option is built in; the final beat is last.
    function automatic void push_word(input logic [W-1:0] d);
        beat_t b;
        for (int i = 0; i < int'(BEATS); i++) begin
            if (i < int'(W)) begin
                b.bit_lsb = d[i];
                b.bit_msb = d[int'(W) - 1 - i];
            end else begin
                b.bit_lsb = ^d;
                b.bit_msb = ^d;
            end
            b.last = (i == int'(BEATS) - 1);
            exp_q.push_back(b);
        end
    endfunction

    // Monitor
    always @(negedge Clk) begin
        beat_t b;
        if (Rst_l === 1'b1) begin
            check("busy_vs_valid_a", busy_a, ser_valid_a);
            check("busy_vs_valid_b", busy_b, ser_valid_b);
            if (ser_valid_a === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got valid beat expected none at %0t", $time);
                end else begin
                    b = exp_q[0];
                    check("ser_out_lsb", ser_out_a, b.bit_lsb);
                    check("ser_out_msb", ser_out_b, b.bit_msb);
                    check("ser_last_lsb", ser_last_a, b.last);
                    check("ser_last_msb", ser_last_b, b.last);
                    check("ser_valid_msb", ser_valid_b, 1'b1);
                    if (Ser_ready === 1'b1) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_outputs", {ser_valid_a, ser_out_a, ser_last_a,
                                       ser_valid_b, ser_out_b, ser_last_b}, '0);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        if (rdy_rand) Ser_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_word(input logic [W-1:0] d);
        D        = d;
        In_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (in_ready_a === 1'b1) begin
                push_word(d);
                tick();
                In_valid = 1'b0;
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no In_ready expected acceptance of %0h", d);
        In_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int cycles);
        cycles = 0;
        for (int n = 0; n < 400; n++) begin
            if (busy_a === 1'b0) begin
                check({name, "_in_ready"}, in_ready_a, 1'b1);
                check({name, "_queue_left"}, 16'(exp_q.size()), 16'd0);
                return;
            end
            tick();
            cycles++;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got Busy=1 expected Busy=0", name);
    endtask

    initial begin
        int cyc;
        Rst_l     = 1'b0;
        In_valid  = 1'b0;
        D         = '0;
        Ser_ready = 1'b0;

        // Reset then release
        repeat (3) @(posedge Clk);
        #1;
        check("reset_outputs", {in_ready_a, ser_out_a, ser_valid_a, ser_last_a, busy_a,
                                in_ready_b, ser_out_b, ser_valid_b, ser_last_b, busy_b}, '0);
        Rst_l = 1'b1;
        check("pre_edge_in_ready", in_ready_a, 1'b0);
        tick();
        check("release_in_ready", in_ready_a, 1'b1);
        check("release_busy", busy_a, 1'b0);

        // Single word, no backpressure: busy for exactly one cycle per beat
        Ser_ready = 1'b1;
        send_word(4'hB);
        wait_idle("single", cyc);
        check("single_cycles", 16'(cyc), 16'(BEATS));

        // Backpressure on beat 2
        send_word(4'h6);
        tick();
        Ser_ready = 1'b0;
        repeat (3) tick();
        Ser_ready = 1'b1;
        wait_idle("stall", cyc);

        // Input offered while busy is ignored until idle
        send_word(4'h5);
        send_word(4'hF);
        wait_idle("ignored", cyc);

        // Reset mid-word clears outputs without a clock edge
        send_word(4'h9);
        tick();
        #1;
        Rst_l = 1'b0;
        #1;
        check("async_reset_outputs", {in_ready_a, ser_out_a, ser_valid_a, ser_last_a, busy_a,
                                      in_ready_b, ser_out_b, ser_valid_b, ser_last_b, busy_b}, '0);
        exp_q.delete();
        tick();
        tick();
        Rst_l = 1'b1;
        tick();
        check("rerelease_in_ready", in_ready_a, 1'b1);
        send_word(4'h3);
        wait_idle("after_reset", cyc);

        // Random words with random backpressure
        rdy_rand = 1'b1;
        for (int k = 0; k < 150; k++) begin
            send_word(W'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
        end
        rdy_rand  = 1'b0;
        Ser_ready = 1'b1;
        wait_idle("random", cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. It is the outbound counterpart of the team's parallel capture registers.
- Accepts a WIDTH-bit word over a valid/ready handshake, then shifts it out one bit per accepted beat on a serial valid/ready stream, marking the final beat.
- Sits between register-level datapath logic and narrow serial links or test pins.

Parameters:
- WIDTH, 4, number of data bits per word (legal range 2..16).
- LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_l  input  1  asynchronous active-low reset.
- D  input  WIDTH  parallel data word.
- In_valid  input  1  D is valid this cycle.
- In_ready  output  1  block can accept a word.
- Ser_ready  input  1  downstream accepts the current serial beat.
- Ser_out  output  1  current serial bit.
- Ser_valid  output  1  Ser_out is valid.
- Ser_last  output  1  current beat is the final beat of the word.
- Busy  output  1  a word is in flight.

Behaviour:
- Interface: single clock Clk; reset Rst_l is asynchronous and active-low.
- All outputs are registered.
- Reset values while Rst_l is low:
  - state IDLE.
  - shift register 0; beat counter 0.
  - In_ready 0, Ser_out 0, Ser_valid 0, Ser_last 0, Busy 0.
- Reset release: the first rising Clk edge with Rst_l high sets In_ready to 1.
- States:
  - IDLE: In_ready=1, Ser_valid=0, Busy=0.
  - SHIFT: In_ready=0, Ser_valid=1, Busy=1.
  - PAR: only with the optional feature; In_ready=0, Ser_valid=1, Busy=1.
- IDLE -> SHIFT: on an edge with In_valid and In_ready both 1.
  - D is captured into the shift register.
  - Beat counter is cleared.
  - Ser_out takes the first bit (per LSB_FIRST) at that same edge, so the first beat is presented one cycle after acceptance.
- Beat transfer: occurs on any edge where Ser_valid and Ser_ready are both 1.
  - The shift register advances one position and the beat counter increments.
  - Ser_out takes the next bit.
- Stall: while Ser_ready=0, Ser_out, Ser_valid and Ser_last hold stable.
- Ser_last = 1 exactly while the final data bit is presented (beat counter == WIDTH-1); without the feature this is the final beat of the word.
- End of word: transfer of the final beat -> IDLE.
  - Ser_valid=0, Ser_last=0, Busy=0, In_ready=1 on that edge.
- Throughput:
  - Minimum WIDTH+1 cycles per word: one acceptance cycle plus WIDTH beats.
  - There is no overlap of acceptance with shifting.
- In_valid while In_ready=0 is ignored and D is not sampled. Upstream must hold D and In_valid until the handshake completes.
- Ser_ready is ignored while Ser_valid=0.
- Reset mid-word: all state clears immediately (asynchronously) and the partial word is discarded; it is never resumed.
- Ser_out is 0 whenever Ser_valid=0.

Optional Feature:
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined:
  - After the final data beat transfers, the FSM enters PAR and presents one extra beat carrying even parity (XOR of all WIDTH bits of the captured word).
  - Ser_last moves from the final data beat to the parity beat.
  - PAR -> IDLE on transfer of the parity beat.
  - Words are WIDTH+1 beats; minimum WIDTH+2 cycles per word.
- Undefined:
  - The PAR state and parity logic are absent.
  - Words are WIDTH beats, with Ser_last on data bit WIDTH-1.

Test Plan (defaults WIDTH=4, LSB_FIRST=1 unless stated):
- Reset then release: hold Rst_l low 3 cycles -> all outputs 0. First edge after release -> In_ready=1, Busy=0.
- Single word: D=4'hB accepted with Ser_ready held 1 -> Ser_out sequence 1,1,0,1 on 4 consecutive cycles, Ser_last only on the 4th beat. Next edge -> In_ready=1. With PARITY_EN -> 5th beat Ser_out=1 with Ser_last; the 4th beat has Ser_last=0.
- Backpressure: D=4'h6, Ser_ready=0 for 3 cycles on beat 2 -> Ser_out=1, Ser_valid=1, Ser_last=0 held stable throughout. After release the sequence completes as 0,1,1,0.
- Ignored input: while Busy=1 drive In_valid=1 with D=4'hF -> no capture. The in-flight word is unaffected, and 4'hF is accepted only after return to IDLE.
- Reset mid-word: assert Rst_l low during beat 2 of D=4'h9 -> outputs clear without waiting for Clk. After release, the next word 4'h3 serializes as 1,1,0,0 with no residue.
- MSB-first: LSB_FIRST=0, D=4'hB -> Ser_out 1,0,1,1 with Ser_last on the 4th beat.
